// File: rtl/stp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stp_pkg
// Description : Shared defaults and the fill-counter width helper for the
//               serial-to-parallel block collector.
// Revision    : 1.0 - initial release
// ============================================================================
package stp_pkg;

  localparam int WORD_W_DEF    = 32;
  localparam int NUM_WORDS_DEF = 8;

  // The fill counter must be able to represent NUM_WORDS itself (a full buffer).
  function automatic int cnt_width(input int num_words);
    return $clog2(num_words + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stp_out_stage.sv
`default_nettype none
// ============================================================================
// Module      : stp_out_stage
// Description : Output holding register with valid/ready handshake. A load
//               always wins over a same-cycle consume so back-to-back blocks
//               leave no valid bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module stp_out_stage #(
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              free_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // The register can take a new block when empty or when being drained now.
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Load captures a new block; otherwise a consumed block drops valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stp_block_collector.sv
`default_nettype none
// ============================================================================
// Module      : stp_block_collector
// Description : Collects NUM_WORDS serial words into a fill buffer and hands
//               each complete block to a double-buffered output register.
// Revision    : 1.0 - initial release
// ============================================================================
module stp_block_collector
  import stp_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int MSW_FIRST = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WORD_W-1:0]                 in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WORD_W*NUM_WORDS-1:0]       out_data,
  output logic [cnt_width(NUM_WORDS)-1:0]   fill_count
);

  localparam int               CNT_W    = cnt_width(NUM_WORDS);
  localparam int               IDX_W    = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_WORDS);

  logic [WORD_W-1:0]           slot_q [NUM_WORDS];
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_d;
  logic [IDX_W-1:0]            wr_idx;
  logic                        accept;
  logic                        transfer;
  logic                        out_free;
  logic [WORD_W*NUM_WORDS-1:0] fill_flat;

  // Ready depends only on the registered fill level, never on inputs.
  assign in_ready   = (cnt_q < FULL_CNT);
  assign accept     = in_valid && in_ready && !clear;
  assign transfer   = (cnt_q == FULL_CNT) && out_free && !clear;
  assign fill_count = cnt_q;

  // While not full the count is below NUM_WORDS, so its low bits index a slot.
  generate
    if (MSW_FIRST != 0) begin : g_msw_first
      assign wr_idx = IDX_W'(NUM_WORDS - 1) - cnt_q[IDX_W-1:0];
    end else begin : g_lsw_first
      assign wr_idx = cnt_q[IDX_W-1:0];
    end
  endgenerate

  // Fill level: clear beats transfer and accept; accept and transfer never coincide.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (transfer) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fill buffer state: counter plus the slot written by an accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        slot_q[wr_idx] <= in_data;
      end
    end
  end

  // Flatten the slots into the block layout, slot k at bits [W*(k+1)-1 : W*k].
  always_comb begin
    fill_flat = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      fill_flat[k*WORD_W +: WORD_W] = slot_q[k];
    end
  end

  stp_out_stage #(
    .DATA_W (WORD_W*NUM_WORDS)
  ) u_out_stage (
    .clk     (clk),
    .rst     (rst),
    .load_i  (transfer),
    .data_i  (fill_flat),
    .ready_i (out_ready),
    .free_o  (out_free),
    .valid_o (out_valid),
    .data_o  (out_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_stp_block_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_stp_block_collector
// Description : Directed and throttled-random bench for stp_block_collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stp_block_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Instance A: defaults, lowest slot first
  logic         rst_a = 1'b1;
  logic         a_clear = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [31:0]  a_in_data = '0;
  logic         a_in_ready, a_out_valid;
  logic [255:0] a_out_data;
  logic [3:0]   a_fill_count;

  // Instance B: defaults, highest slot first
  logic         rst_bc = 1'b1;
  logic         b_clear = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [31:0]  b_in_data = '0;
  logic         b_in_ready, b_out_valid;
  logic [255:0] b_out_data;
  logic [3:0]   b_fill_count;

  // Instance C: 8-bit words, 3 words per block
  logic         c_clear = 1'b0, c_in_valid = 1'b0, c_out_ready = 1'b0;
  logic [7:0]   c_in_data = '0;
  logic         c_in_ready, c_out_valid;
  logic [23:0]  c_out_data;
  logic [1:0]   c_fill_count;

  stp_block_collector #(.WORD_W(32), .NUM_WORDS(8), .MSW_FIRST(0)) u_a (
    .clk(clk), .rst(rst_a), .clear(a_clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .fill_count(a_fill_count));

  stp_block_collector #(.WORD_W(32), .NUM_WORDS(8), .MSW_FIRST(1)) u_b (
    .clk(clk), .rst(rst_bc), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .fill_count(b_fill_count));

  stp_block_collector #(.WORD_W(8), .NUM_WORDS(3), .MSW_FIRST(0)) u_c (
    .clk(clk), .rst(rst_bc), .clear(c_clear), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .fill_count(c_fill_count));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    tests_run++;
    if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b want 0", a_out_valid); end
    tests_run++;
    if (a_out_data !== 256'd0) begin tests_failed++; $display("FAIL reset_out_data: got %h want 0", a_out_data); end
    tests_run++;
    if (a_fill_count !== 4'd0) begin tests_failed++; $display("FAIL reset_fill_count: got %0d want 0", a_fill_count); end
    rst_a  = 1'b0;
    rst_bc = 1'b0;
    step();
    tests_run++;
    if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b want 1", a_in_ready); end
  endtask

  task automatic test_stream_lsw();
    logic [255:0] exp;
    for (int k = 0; k < 8; k++) exp[k*32 +: 32] = 32'(k + 1);
    a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'(i + 1);
      tests_run++;
      if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL lsw_ready_word%0d: got %0b want 1", i, a_in_ready); end
      step();
    end
    a_in_valid = 1'b0;
    tests_run++;
    if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL lsw_ready_low: got %0b want 0", a_in_ready); end
    tests_run++;
    if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL lsw_valid_early: got %0b want 0", a_out_valid); end
    tests_run++;
    if (a_fill_count !== 4'd8) begin tests_failed++; $display("FAIL lsw_full_count: got %0d want 8", a_fill_count); end
    step();
    tests_run++;
    if (a_out_valid !== 1'b1) begin tests_failed++; $display("FAIL lsw_valid: got %0b want 1", a_out_valid); end
    tests_run++;
    if (a_out_data !== exp) begin tests_failed++; $display("FAIL lsw_data: got %h want %h", a_out_data, exp); end
    tests_run++;
    if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL lsw_ready_back: got %0b want 1", a_in_ready); end
    tests_run++;
    if (a_fill_count !== 4'd0) begin tests_failed++; $display("FAIL lsw_count_zero: got %0d want 0", a_fill_count); end
    step();
    tests_run++;
    if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL lsw_valid_fall: got %0b want 0", a_out_valid); end
  endtask

  task automatic test_stream_msw();
    logic [255:0] exp;
    for (int k = 0; k < 8; k++) exp[k*32 +: 32] = 32'(8 - k);
    b_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 32'(i + 1);
      step();
    end
    b_in_valid = 1'b0;
    tests_run++;
    if (b_in_ready !== 1'b0) begin tests_failed++; $display("FAIL msw_ready_low: got %0b want 0", b_in_ready); end
    step();
    tests_run++;
    if (b_out_valid !== 1'b1) begin tests_failed++; $display("FAIL msw_valid: got %0b want 1", b_out_valid); end
    tests_run++;
    if (b_out_data !== exp) begin tests_failed++; $display("FAIL msw_data: got %h want %h", b_out_data, exp); end
    tests_run++;
    if (b_in_ready !== 1'b1) begin tests_failed++; $display("FAIL msw_ready_back: got %0b want 1", b_in_ready); end
  endtask

  task automatic test_backpressure();
    logic [255:0] blk1, blk2;
    int acc, cycles;
    logic took;
    for (int k = 0; k < 8; k++) begin
      blk1[k*32 +: 32] = 32'h100 + 32'(k);
      blk2[k*32 +: 32] = 32'h108 + 32'(k);
    end
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    acc = 0;
    cycles = 0;
    while (acc < 16 && cycles < 100) begin
      a_in_data = 32'h100 + 32'(acc);
      took = a_in_ready;
      step();
      cycles++;
      if (took) acc++;
      if (a_out_valid === 1'b1) begin
        tests_run++;
        if (a_out_data !== blk1) begin tests_failed++; $display("FAIL bp_hold_fill: got %h want %h", a_out_data, blk1); end
      end
    end
    tests_run++;
    if (acc != 16) begin tests_failed++; $display("FAIL bp_accept_timeout: got %0d words want 16", acc); end
    for (int h = 0; h < 3; h++) begin
      step();
      tests_run++;
      if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_low: got %0b want 0", a_in_ready); end
      tests_run++;
      if (a_fill_count !== 4'd8) begin tests_failed++; $display("FAIL bp_fill_hold: got %0d want 8", a_fill_count); end
      tests_run++;
      if (a_out_valid !== 1'b1 || a_out_data !== blk1) begin
        tests_failed++; $display("FAIL bp_out_hold: got v=%0b %h want v=1 %h", a_out_valid, a_out_data, blk1);
      end
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    tests_run++;
    if (a_out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_no_bubble: got %0b want 1", a_out_valid); end
    tests_run++;
    if (a_out_data !== blk2) begin tests_failed++; $display("FAIL bp_block2: got %h want %h", a_out_data, blk2); end
    tests_run++;
    if (a_fill_count !== 4'd0 || a_in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_fill_free: got cnt=%0d rdy=%0b want cnt=0 rdy=1", a_fill_count, a_in_ready);
    end
    a_out_ready = 1'b1;
    step();
    tests_run++;
    if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drain: got %0b want 0", a_out_valid); end
  endtask

  task automatic test_clear();
    logic [255:0] exp;
    for (int k = 0; k < 8; k++) exp[k*32 +: 32] = 32'h200 + 32'(k);
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'hDEAD0001 + 32'(i);
      step();
    end
    tests_run++;
    if (a_fill_count !== 4'd3) begin tests_failed++; $display("FAIL clr_pre_count: got %0d want 3", a_fill_count); end
    a_clear   = 1'b1;
    a_in_data = 32'h00000BAD;
    step();
    a_clear = 1'b0;
    tests_run++;
    if (a_fill_count !== 4'd0) begin tests_failed++; $display("FAIL clr_count: got %0d want 0", a_fill_count); end
    for (int i = 0; i < 8; i++) begin
      a_in_data = 32'h200 + 32'(i);
      step();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    step();
    tests_run++;
    if (a_out_valid !== 1'b1 || a_out_data !== exp) begin
      tests_failed++; $display("FAIL clr_block: got v=%0b %h want v=1 %h", a_out_valid, a_out_data, exp);
    end
    a_clear = 1'b1;
    step();
    a_clear = 1'b0;
    tests_run++;
    if (a_out_valid !== 1'b1 || a_out_data !== exp) begin
      tests_failed++; $display("FAIL clr_output_kept: got v=%0b %h want v=1 %h", a_out_valid, a_out_data, exp);
    end
    a_out_ready = 1'b1;
    step();
    tests_run++;
    if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_drain: got %0b want 0", a_out_valid); end
  endtask

  task automatic test_reset_mid();
    int acc, cycles;
    logic took;
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    acc = 0;
    cycles = 0;
    while (acc < 13 && cycles < 60) begin
      a_in_data = 32'h300 + 32'(acc);
      took = a_in_ready;
      step();
      cycles++;
      if (took) acc++;
    end
    tests_run++;
    if (a_fill_count !== 4'd5 || a_out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_setup: got cnt=%0d v=%0b want cnt=5 v=1", a_fill_count, a_out_valid);
    end
    rst_a       = 1'b1;
    a_clear     = 1'b1;
    a_out_ready = 1'b1;
    step();
    rst_a   = 1'b0;
    a_clear = 1'b0;
    a_in_valid = 1'b0;
    tests_run++;
    if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_valid: got %0b want 0", a_out_valid); end
    tests_run++;
    if (a_out_data !== 256'd0) begin tests_failed++; $display("FAIL rstmid_data: got %h want 0", a_out_data); end
    tests_run++;
    if (a_fill_count !== 4'd0) begin tests_failed++; $display("FAIL rstmid_count: got %0d want 0", a_fill_count); end
    tests_run++;
    if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_ready: got %0b want 1", a_in_ready); end
  endtask

  task automatic test_random();
    logic [7:0]  model_q [$];
    logic [7:0]  wcnt, sent, w0, w1, w2;
    logic [23:0] got, exp;
    logic        acc, take;
    int          blocks, cycles;
    wcnt = 8'd0;
    blocks = 0;
    cycles = 0;
    while (blocks < 1000 && cycles < 40000) begin
      c_in_valid  = ($urandom_range(0, 3) != 0);
      c_in_data   = wcnt;
      c_out_ready = ($urandom_range(0, 2) != 0);
      sent = c_in_data;
      acc  = c_in_valid && c_in_ready;
      take = c_out_valid && c_out_ready;
      got  = c_out_data;
      step();
      cycles++;
      if (take) begin
        blocks++;
        tests_run++;
        if (model_q.size() < 3) begin
          tests_failed++; $display("FAIL rand_underflow: block %0d got %h with only %0d words sent", blocks, got, model_q.size());
        end else begin
          w0 = model_q.pop_front();
          w1 = model_q.pop_front();
          w2 = model_q.pop_front();
          exp = {w2, w1, w0};
          if (got !== exp) begin tests_failed++; $display("FAIL rand_block%0d: got %h want %h", blocks, got, exp); end
        end
      end
      if (acc) begin
        model_q.push_back(sent);
        wcnt = wcnt + 8'd1;
      end
    end
    c_in_valid = 1'b0;
    tests_run++;
    if (blocks != 1000) begin tests_failed++; $display("FAIL rand_timeout: got %0d blocks want 1000", blocks); end
  endtask

  initial begin
    test_reset();
    test_stream_lsw();
    test_stream_msw();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stp_block_collector.md
STP_BLOCK_COLLECTOR -- requirements
Module: stp_block_collector

Interface
REQ-001 The block SHALL have parameter WORD_W, default 32, meaning the width of one input word in bits.
REQ-002 The block SHALL have parameter NUM_WORDS, default 8, meaning the number of words per block, legal range 2..64.
REQ-003 The block SHALL have parameter MSW_FIRST, default 0, meaning word order: 0 = first word lands in the lowest slot, 1 = first word lands in the highest slot.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, all logic rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous discard of the partially filled block.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-009 The block SHALL have port in_data, input, WORD_W bits: the serial word.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data holds a complete block.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the block.
REQ-012 The block SHALL have port out_data, output, WORD_W*NUM_WORDS bits: the parallel block, slot k = bits [WORD_W*(k+1)-1 : WORD_W*k].
REQ-013 The block SHALL have port fill_count, output, CNT_W = $clog2(NUM_WORDS+1) bits: the number of words in the fill buffer.

Function
REQ-014 Structure: fill buffer (NUM_WORDS slots plus fill_count) feeding one output holding register (double buffering).
REQ-015 Word accept occurs on a rising edge with in_valid && in_ready && !clear.
REQ-016 in_ready SHALL equal (fill_count < NUM_WORDS) and SHALL be combinational from registered state only.
REQ-017 An accepted word SHALL be written to slot fill_count (MSW_FIRST=0) or slot NUM_WORDS-1-fill_count (MSW_FIRST=1), and fill_count SHALL increment.
REQ-018 Transfer: on an edge where fill_count == NUM_WORDS and (!out_valid || out_ready), out_data SHALL load the fill buffer, out_valid SHALL be 1, and fill_count SHALL be 0.
REQ-019 Latency: the edge accepting the last word is edge E; out_valid SHALL rise at E+1 when the output is free, and in_ready SHALL be low for exactly one cycle per block.
REQ-020 If the output is occupied and out_ready is low, the full fill buffer SHALL hold and in_ready SHALL stay low (back-pressure) until the transfer occurs.
REQ-021 On an edge with out_valid && out_ready and no transfer, out_valid SHALL fall.
REQ-022 On an edge with out_ready and a transfer together, out_valid SHALL stay 1 with the new block (no bubble).
REQ-023 out_data SHALL be stable while out_valid && !out_ready.
REQ-024 clear SHALL set fill_count to 0 and SHALL have priority over a same-edge accept (the word is dropped) and over a same-edge transfer; the output register and out_valid SHALL be unaffected by clear.
REQ-025 Slot contents not yet written in the current block SHALL retain stale data; only out_data after a transfer is defined.

Reset
REQ-026 On rst, the block SHALL set fill_count=0, out_valid=0, out_data=0 and fill slots=0; rst SHALL override clear and all handshakes.
REQ-027 Reset asserted mid-block or with out_valid high SHALL discard all data; in_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-028 A shared package stp_pkg SHALL hold the default WORD_W and NUM_WORDS localparams and the CNT_W computation function.
REQ-029 The output holding register with valid/ready SHALL be a sub-module named stp_out_stage, parameterised by total width; all other logic SHALL be in stp_block_collector.

Verification
REQ-030 Scenario: defaults, MSW_FIRST=0, out_ready=1, words 0x00000001..0x00000008 streamed back-to-back -> out_valid one cycle after the 8th accept, out_data = 0x00000008_..._00000001, in_ready low one cycle.
REQ-031 Scenario: MSW_FIRST=1, same stream -> out_data = 0x00000001_00000002_..._00000008.
REQ-032 Scenario: out_ready=0, 16 words offered -> first block held stable, second block fills, in_ready stays low after word 16; out_ready pulsed for one cycle -> second block appears on the next cycle with no out_valid bubble.
REQ-033 Scenario: 3 words accepted, then clear with in_valid high -> fill_count=0, the word is dropped, the next 8 words form a clean block.
REQ-034 Scenario: rst asserted with fill_count=5 and out_valid=1 -> next cycle out_valid=0, out_data=0, fill_count=0, in_ready=1.
REQ-035 Scenario: WORD_W=8, NUM_WORDS=3, random valid/ready throttling over 1000 blocks -> scoreboard matches the block sequence with no loss or duplication.
